// File: rtl/fir_out_fifo.sv
// Output FIFO behind the FIR filter: registered storage with a valid/ready read
// side and a drop-on-full write side. Optional drop counter: FIR_OUT_FIFO_DROPCNT_EN.
module fir_out_fifo #(
  parameter int DW    = 19,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  input  logic          clr_ovf,
  output logic [7:0]    drop_count
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, drop;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LVL_FULL);
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr_q];
  assign level     = level_q;
  assign overflow  = ovf_q;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

`ifdef FIR_OUT_FIFO_DROPCNT_EN
  logic [7:0] dcnt_q, dcnt_d;

  always_comb begin
    dcnt_d = dcnt_q;
    if (clr_ovf)                   dcnt_d = drop ? 8'd1 : 8'd0;
    else if (drop && dcnt_q != '1) dcnt_d = dcnt_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) dcnt_q <= '0;
    else        dcnt_q <= dcnt_d;
  end

  assign drop_count = dcnt_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_fir_out_fifo.sv
// Randomized + directed bench for fir_out_fifo against a queue-based model.
module tb_fir_out_fifo;
  localparam int DW = 19, DEPTH = 8, AW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid, out_ready, clr_ovf;
  logic [DW-1:0] in_data;
  logic          out_valid, full, empty, overflow;
  logic [DW-1:0] out_data;
  logic [AW:0]   level;
  logic [7:0]    drop_count;

  always #5 clock = ~clock;

  fir_out_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .full(full), .empty(empty), .overflow(overflow),
    .clr_ovf(clr_ovf), .drop_count(drop_count)
  );

  int n_chk = 0, n_fail = 0;

  // Reference model
  logic [DW-1:0] q[$];
  bit            m_ovf;
  int            m_dcnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int exp_dcnt();
`ifdef FIR_OUT_FIFO_DROPCNT_EN
    return m_dcnt;
`else
    return 0;
`endif
  endfunction

  task automatic check_state();
    chk("out_valid", out_valid, q.size() != 0);
    chk("level", level, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0);
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, exp_dcnt());
    if (q.size() != 0) chk("out_data", out_data, q[0]);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 0;
    m_dcnt = 0;
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit rdy, input bit clr);
    bit pop, push, drop;
    in_valid = v; in_data = d; out_ready = rdy; clr_ovf = clr;
    pop  = rdy && q.size() != 0;
    push = v && (q.size() < DEPTH || pop);
    drop = v && q.size() == DEPTH && !pop;
    @(posedge clock);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(d);
    if (drop)     m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (clr)                     m_dcnt = drop ? 1 : 0;
    else if (drop && m_dcnt < 255) m_dcnt++;
    #1;
    check_state();
  endtask

  initial begin
    in_valid = 0; in_data = '0; out_ready = 0; clr_ovf = 0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_count", drop_count, 0);

    // Single sample, then pop it
    step(1, 19'h7FFFF, 0, 0);
    chk("single_data", out_data, 19'h7FFFF);
    chk("single_level", level, 1);
    step(0, '0, 1, 0);
    chk("single_empty", empty, 1);

    // Fill, drain, then wrap
    for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0);
    chk("fill_full", full, 1);
    chk("fill_level", level, 8);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", out_data, i);
      step(0, '0, 1, 0);
    end
    for (int i = 9; i <= 12; i++) step(1, DW'(i), 0, 0);
    for (int i = 9; i <= 12; i++) begin
      chk("wrap_order", out_data, i);
      step(0, '0, 1, 0);
    end

    // Overflow on a full FIFO
    for (int i = 0; i < 8; i++) step(1, DW'($urandom), 0, 0);
    for (int i = 0; i < 3; i++) step(1, DW'($urandom), 0, 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_level", level, 8);
`ifdef FIR_OUT_FIFO_DROPCNT_EN
    chk("ovf_dcnt", drop_count, 3);
`else
    chk("ovf_dcnt", drop_count, 0);
`endif
    step(0, '0, 0, 1);
    chk("clr_flag", overflow, 0);
    chk("clr_dcnt", drop_count, 0);

    // Full with simultaneous pop: no drop, head advances
    for (int i = 0; i < 4; i++) step(1, DW'(32'h100 + i), 1, 0);
    chk("fullpop_level", level, 8);
    chk("fullpop_ovf", overflow, 0);

    // Saturation, then drop together with clear
    for (int i = 0; i < 300; i++) step(1, DW'($urandom), 0, 0);
`ifdef FIR_OUT_FIFO_DROPCNT_EN
    chk("sat_dcnt", drop_count, 255);
`else
    chk("sat_dcnt", drop_count, 0);
`endif
    step(1, DW'($urandom), 0, 1);
    chk("dropclr_ovf", overflow, 1);
`ifdef FIR_OUT_FIFO_DROPCNT_EN
    chk("dropclr_dcnt", drop_count, 1);
`else
    chk("dropclr_dcnt", drop_count, 0);
`endif

    // Drain, then a full-rate burst with an always-ready consumer
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
    for (int i = 0; i < 12; i++) begin
      step(1, DW'($urandom), 1, 0);
      chk("burst_le1", level <= 1, 1);
    end
    step(0, '0, 1, 1);

    // Random traffic with shifting consumer duty
    for (int i = 0; i < 600; i++) begin
      int rp;
      rp = (i / 100) % 3 == 0 ? 20 : ((i / 100) % 3 == 1 ? 50 : 85);
      step($urandom_range(99) < 60, DW'($urandom), $urandom_range(99) < rp,
           $urandom_range(99) < 4);
    end

    // Asynchronous reset with five entries stored
    model_reset();
    step(0, '0, 1, 1);
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, DW'($urandom), 0, 0);
    chk("pre_rst_level", level, 5);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("arst_out_valid", out_valid, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_level", level, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_drop_count", drop_count, 0);
    @(negedge clock) reset = 1'b1;
    step(1, 19'h12345, 0, 0);
    chk("post_rst_data", out_data, 19'h12345);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_out_fifo.md
# fir_out_fifo

Output buffer stage placed directly downstream of the FIR filter top. It captures every 19-bit filter result presented with `valid_out`, stores up to DEPTH results, and hands them to the consumer over a valid/ready handshake. The FIR has no backpressure, so the FIFO never stalls it: when the FIFO is full, samples are dropped and flagged.

## Interface
- `DW`, 19, data width; matches the FIR `y` output.
- `DEPTH`, 8, entries; power of two, ≥2.
- `AW`, 3, log2(DEPTH); set consistently with DEPTH.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  sample strobe; connect to FIR `valid_out`.
- `in_data`  in  DW  sample; connect to FIR `y`.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts head entry.
- `out_data`  out  DW  head entry.
- `level`  out  AW+1  number of stored entries, 0..DEPTH.
- `full`  out  1  level == DEPTH.
- `empty`  out  1  level == 0.
- `overflow`  out  1  sticky; set when a sample is dropped.
- `clr_ovf`  in  1  synchronous clear of `overflow` (and of `drop_count` when present).
- `drop_count`  out  8  saturating count of dropped samples; see Configuration.

## Operation
- Storage: DEPTH×DW register array, write pointer `wr_ptr[AW-1:0]`, read pointer `rd_ptr[AW-1:0]`, counter `level[AW:0]`. Both pointers wrap modulo DEPTH.
- Push condition: `in_valid && (!full || pop)`. On a push, write `in_data` to `mem[wr_ptr]` and increment `wr_ptr`.
- Pop condition: `out_valid && out_ready`. On a pop, increment `rd_ptr`.
- Level update: push only gives +1. Pop only gives −1. Push and pop together leave the level unchanged. Neither leaves it unchanged.
- `out_data` is `mem[rd_ptr]` read combinationally. `out_valid` is `!empty`. `full` and `empty` decode from `level`.
- Drop: `in_valid && full && !pop`. The sample is discarded and no storage changes. `overflow` is set the next edge.
- Simultaneous drop and `clr_ovf`: the set wins, so `overflow` stays 1.
- `clr_ovf` has no effect on stored data or pointers.
- No explicit state machine. Pointers and level form the state. The implementation must keep `level` consistent with pointer difference at all times. An implicit empty/partial/full state is permitted.
- Reset (asynchronous, any time, including mid-burst): pointers = 0, level = 0, `overflow` = 0, `drop_count` = 0. Memory contents are not reset.
- Reset output values: `out_valid` = 0, `empty` = 1, `full` = 0, `level` = 0, `overflow` = 0, `drop_count` = 0. `out_data` is undefined while `out_valid` = 0.

## Timing
- Write-to-read latency is 1 cycle. A sample pushed at edge N is visible on `out_data` with `out_valid` = 1 after edge N. There is no same-cycle bypass when empty.
- `out_data` is stable while `out_valid && !out_ready`. The consumer may hold `out_ready` low indefinitely.
- `out_ready` asserted while `out_valid` = 0 has no effect.
- Full with simultaneous pop accepts the incoming sample, so there is no drop and `level` stays DEPTH.
- A FIR burst of 1 sample per cycle, with the consumer always ready, runs with `level` ≤ 1.
- Flags and `level` update on the same edge as the pointer change. All outputs are registered except `out_data`, `out_valid`, `full` and `empty`, which decode from registers.

## Configuration
- `FIR_OUT_FIFO_DROPCNT_EN` defined:
  - `drop_count` is an 8-bit register.
  - It increments on each drop and saturates at 255.
  - It is cleared by `clr_ovf` (same edge).
  - If a drop and `clr_ovf` occur on the same cycle, the result is 1.
- Not defined:
  - `drop_count` is tied to 0 and no counter logic is built.
  - `overflow` behaviour is unchanged.

## Test plan
- Reset: deassert `reset` with no input → `out_valid` = 0, `empty` = 1, `level` = 0, `overflow` = 0, `drop_count` = 0. Assert `reset` with `level` = 5 → all of these return to reset values immediately, without waiting for a clock edge.
- Single sample: push 0x7FFFF with `out_ready` = 0 → next cycle `out_valid` = 1, `out_data` = 0x7FFFF, `level` = 1. Raise `out_ready` for one cycle → `empty` = 1.
- Fill and wrap: with `out_ready` = 0, push 1..8 → `full` = 1, `level` = 8. Drain with `out_ready` = 1 → outputs 1..8 in order. Then push 9..12 → read back 9..12 across the pointer wrap.
- Overflow: with `full` = 1 and `out_ready` = 0, push 3 samples → `overflow` = 1, `drop_count` = 3 (macro defined) or 0 (undefined), and `level` stays 8. Pulse `clr_ovf` → `overflow` = 0, `drop_count` = 0.
- Full with pop: with `full` = 1, apply `in_valid` and `out_ready` together for 4 cycles pushing 0x100..0x103 → no drop, `level` stays 8, and the head advances through the 4 oldest entries.
- Saturation (macro defined): apply 300 drops → `drop_count` = 255. Then assert a drop and `clr_ovf` on the same cycle → `drop_count` = 1, `overflow` = 1.
